// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter: one AR->R transaction in flight at a time,
// round-robin on ties, address registered toward the slave.
module axi_lite_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;

    logic [1:0]        req;
    logic              pick;
    logic [1:0]        m_arready;
    logic [1:0]        m_rvalid;
    logic [1:0]        fwd;
    logic [DATA_W-1:0] m_rdata [2];
    logic [1:0]        m_rresp [2];

    assign req  = {m1_arvalid, m0_arvalid};
    // M1 wins when it is the only requester, or on a tie when M0 was served last
    assign pick = req[1] & (~req[0] | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d  = pick;
                    araddr_d = pick ? m1_araddr : m0_araddr;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_rvalid && s_rready) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            // arready is combinational, so it is also masked while reset is asserted
            assign m_arready[gi] = resetn && (state_q == IDLE) && req[gi] && (pick == (gi == 1));
            assign fwd[gi]       = (state_q == DATA) && (grant_q == (gi == 1));
            assign m_rvalid[gi]  = fwd[gi] && s_rvalid;
            assign m_rdata[gi]   = fwd[gi] ? s_rdata : '0;
            assign m_rresp[gi]   = fwd[gi] ? s_rresp : 2'b00;
        end
    endgenerate

    assign m0_arready = m_arready[0];
    assign m1_arready = m_arready[1];
    assign m0_rvalid  = m_rvalid[0];
    assign m1_rvalid  = m_rvalid[1];
    assign m0_rdata   = m_rdata[0];
    assign m1_rdata   = m_rdata[1];
    assign m0_rresp   = m_rresp[0];
    assign m1_rresp   = m_rresp[1];

    assign s_arvalid  = (state_q == ADDR);
    assign s_araddr   = s_arvalid ? araddr_q : '0;
    assign s_rready   = (state_q == DATA) && (grant_q ? m1_rready : m0_rready);

endmodule
